regfile_mp_sb: RTL and testbench
================================

# regfile_mp_sb

Parametrised multi-port integer register file with write bypass and a register scoreboard, replacing the single-write, two-read register file in the core. It sits between decode/issue and writeback. It serves NRD combinational read ports and NWR write ports, and tracks a busy bit per architectural register so issue can detect RAW hazards. Register contents are cleared by a post-reset sweep FSM rather than a one-cycle flash clear, so the array can map to RAM.

## Interface
- XLEN, 64: data width; equals the width of CorePack::data_t.
- NREG, 32: number of architectural registers; power of two, ≥4.
- NRD, 2: number of read ports.
- NWR, 1: number of write ports, 1..4.
- BYPASS, 1: 1 = a same-cycle write is forwarded to reads and clears busy as seen by readers; 0 = no forwarding.
- AW, $clog2(NREG): address width (derived; not overridable).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- ready  out  1  high once the clear sweep has finished; reset value 0.
- rd_addr  in  NRD×AW  read addresses.
- rd_data  out  NRD×XLEN  read data, combinational.
- rd_busy  out  NRD×1  busy bit of the addressed register, combinational.
- we  in  NWR  per-port write enable.
- wa  in  NWR×AW  write addresses.
- wd  in  NWR×XLEN  write data.
- rsv_en  in  1  reserve a destination register (set its busy bit).
- rsv_addr  in  AW  register to reserve.

## Operation
- Register 0 is hardwired zero:
  - Reads return 0 and rd_busy=0.
  - Writes and reservations to register 0 are ignored.
- States are SWEEP and RUN.
- rst (any cycle, including mid-sweep or mid-run) → SWEEP on the next edge:
  - sweep counter = 1, all busy bits = 0, ready = 0.
- SWEEP behaviour:
  - Writes register[cnt] ← 0 once per cycle; cnt increments.
  - When cnt = NREG-1 is written, the FSM enters RUN and ready=1 on the following cycle.
  - The sweep takes NREG-1 cycles from rst deassertion to ready.
- While in SWEEP:
  - we and rsv_en are ignored.
  - rd_data=0 and rd_busy=0.
- In RUN:
  - Each enabled write port updates its register at the clock edge and clears that register's busy bit.
- Write-port conflict: if several ports write the same address in one cycle, the highest port index wins, both for the data and for the bypass.
- Reserve/clear collision: rsv_en and a write to the same register in the same cycle leave busy=1. The reservation represents a newer producer.
- Bypass (BYPASS=1):
  - If any we[j] targets rd_addr[i] (≠0) this cycle, rd_data[i] = the winning wd, and rd_busy[i] = 0 unless rsv_en targets the same register in the same cycle.
- BYPASS=0: reads reflect state as of the last edge only.
- Reservation of an already-busy register keeps busy=1. The file keeps no count of producers; issue must not reserve twice without an intervening write.

## Timing
- Reads are zero-latency (combinational from rd_addr, we, wa, wd, and state).
- Write data is visible to non-bypassed reads on the cycle after the edge that writes it.
- A reservation is visible in rd_busy on the cycle after rsv_en.
- Reset values:
  - ready=0.
  - All busy bits 0.
  - rd_data=0 and rd_busy=0 until ready.
- Register contents are undefined until the sweep reaches them. Outputs are masked, so this is not observable.

## Structure
- Add to CorePack:
  - reg_ind_t sized from NREG.
  - An rf_state_e enum (SWEEP, RUN).
- data_t stays XLEN-parametrised locally via the parameter.
- Sub-module rf_scoreboard holds:
  - The NREG busy vector.
  - The set/clear priority logic.
  - The per-read-port busy lookup with bypass.
- The top level holds:
  - The data array.
  - The sweep FSM.
  - The write-priority and forwarding muxes.

## Test plan
- Sweep: pulse rst for 1 cycle → ready stays 0 for exactly 31 cycles (NREG=32), then goes to 1. A write issued during the sweep is ignored, and all registers read 0.
- Basic write/read: write x5=0xDEAD_BEEF in RUN → read port 0 returns it the next cycle. Writing x0=0x1234 → x0 still reads 0.
- Bypass: BYPASS=1, we=1, wa=7, wd=0x55 → rd_addr[1]=7 returns 0x55 in the same cycle. With BYPASS=0, the same stimulus returns the old value in that cycle and 0x55 in the next.
- Port conflict: NWR=2, both ports write x9 (0x11 on port 0, 0x22 on port 1) → x9 reads 0x22, and bypass also shows 0x22.
- Scoreboard:
  - rsv x3 → rd_busy=1 the next cycle.
  - A write to x3 together with rsv_en on x3 → busy remains 1.
  - A subsequent write without rsv → busy clears, and rd_busy=0 in the same cycle under bypass.
- Reset mid-run: busy x4 and x6 set, x4=0x99; assert rst → ready=0, all rd_busy=0, and x4 reads 0 after the new sweep completes.

Source files
------------

// File: rtl/regfile_mp_sb_pkg.sv
// Shared types for the multi-port register file: register index and sweep/run state.
package regfile_mp_sb_pkg;

    localparam int unsigned NREG_DEF = 32;

    typedef logic [$clog2(NREG_DEF)-1:0] reg_ind_t;

    typedef enum logic {
        StSweep,
        StRun
    } rf_state_e;

endpackage

// File: rtl/regfile_mp_sb_scoreboard.sv
// Per-register busy bits: reservation sets, writes clear, reservation wins a same-cycle collision.
module regfile_mp_sb_scoreboard
    import regfile_mp_sb_pkg::*;
#(
    parameter int unsigned NREG   = 32,
    parameter int unsigned NRD    = 2,
    parameter int unsigned NWR    = 1,
    parameter int unsigned BYPASS = 1,
    localparam int unsigned AW    = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [NWR-1:0]    we,
    input  logic [NWR*AW-1:0] wa,
    input  logic              rsv_en,
    input  logic [AW-1:0]     rsv_addr,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD-1:0]    rd_busy
);

    logic [NREG-1:0] busy_q, busy_d;

    always_comb begin
        busy_d = busy_q;
        if (run) begin
            for (int j = 0; j < NWR; j++) begin
                if (we[j]) busy_d[wa[j*AW +: AW]] = 1'b0;
            end
            if (rsv_en) busy_d[rsv_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    always_comb begin : busy_lookup
        logic [AW-1:0] ra;
        logic          hit;
        rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            ra  = rd_addr[i*AW +: AW];
            hit = 1'b0;
            for (int j = 0; j < NWR; j++) begin
                if (we[j] && (wa[j*AW +: AW] == ra)) hit = 1'b1;
            end
            rd_busy[i] = busy_q[ra];
            // A same-cycle reservation of this register is a newer producer; keep it busy.
            if ((BYPASS != 0) && hit && !(rsv_en && (rsv_addr == ra))) rd_busy[i] = 1'b0;
            if (!run || (ra == '0)) rd_busy[i] = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with write bypass, busy scoreboard and a post-reset clear sweep.
module regfile_mp_sb
    import regfile_mp_sb_pkg::*;
#(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned NREG   = 32,
    parameter int unsigned NRD    = 2,
    parameter int unsigned NWR    = 1,
    parameter int unsigned BYPASS = 1,
    localparam int unsigned AW    = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    output logic                ready,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      we,
    input  logic [NWR*AW-1:0]   wa,
    input  logic [NWR*XLEN-1:0] wd,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr
);

    typedef logic [XLEN-1:0] data_t;

    rf_state_e     state_q;
    logic [AW-1:0] cnt_q;
    logic          ready_q;
    logic          run;
    data_t         mem [NREG];

    assign run   = (state_q == StRun);
    assign ready = ready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StSweep;
            cnt_q   <= AW'(1);
            ready_q <= 1'b0;
        end else if (state_q == StSweep) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == AW'(NREG - 1)) begin
                state_q <= StRun;
                ready_q <= 1'b1;
            end
        end
    end

    // No reset on the array so it can map to RAM; the sweep zeroes it instead.
    always_ff @(posedge clk) begin
        if (state_q == StSweep) begin
            mem[cnt_q] <= '0;
        end else if (!rst) begin
            for (int j = 0; j < NWR; j++) begin
                if (we[j] && (wa[j*AW +: AW] != '0)) mem[wa[j*AW +: AW]] <= wd[j*XLEN +: XLEN];
            end
        end
    end

    always_comb begin : rd_mux
        logic [AW-1:0] ra;
        data_t         rv;
        rd_data = '0;
        for (int i = 0; i < NRD; i++) begin
            ra = rd_addr[i*AW +: AW];
            rv = mem[ra];
            if (BYPASS != 0) begin
                // Later ports override earlier ones, matching write priority.
                for (int j = 0; j < NWR; j++) begin
                    if (we[j] && (wa[j*AW +: AW] == ra)) rv = wd[j*XLEN +: XLEN];
                end
            end
            if (run && (ra != '0)) rd_data[i*XLEN +: XLEN] = rv;
        end
    end

    regfile_mp_sb_scoreboard #(
        .NREG   (NREG),
        .NRD    (NRD),
        .NWR    (NWR),
        .BYPASS (BYPASS)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .we       (we),
        .wa       (wa),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .rd_addr  (rd_addr),
        .rd_busy  (rd_busy)
    );

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Bench for regfile_mp_sb: a bypassing and a non-bypassing instance share one stimulus stream.
module tb_regfile_mp_sb;

    localparam int unsigned XLEN = 64;
    localparam int unsigned NREG = 32;
    localparam int unsigned NRD  = 2;
    localparam int unsigned NWR  = 2;
    localparam int unsigned AW   = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic                ready, ready_nb;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data, rd_data_nb;
    logic [NRD-1:0]      rd_busy, rd_busy_nb;
    logic [NWR-1:0]      we;
    logic [NWR*AW-1:0]   wa;
    logic [NWR*XLEN-1:0] wd;
    logic                rsv_en;
    logic [AW-1:0]       rsv_addr;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    regfile_mp_sb #(
        .XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(1)
    ) dut (
        .clk(clk), .rst(rst), .ready(ready), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_busy(rd_busy), .we(we), .wa(wa), .wd(wd), .rsv_en(rsv_en), .rsv_addr(rsv_addr)
    );

    regfile_mp_sb #(
        .XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(0)
    ) dut_nb (
        .clk(clk), .rst(rst), .ready(ready_nb), .rd_addr(rd_addr), .rd_data(rd_data_nb),
        .rd_busy(rd_busy_nb), .we(we), .wa(wa), .wd(wd), .rsv_en(rsv_en), .rsv_addr(rsv_addr)
    );

    typedef struct {
        string       name;
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [63:0] wd0;
        logic [4:0]  wa1;
        logic [63:0] wd1;
        logic        rsv_en;
        logic [4:0]  rsv_addr;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [63:0] bd0, bd1;
        logic [1:0]  bb;
        logic [63:0] nd0, nd1;
        logic [1:0]  nb;
    } vec_t;

    typedef struct {
        string        name;
        logic [127:0] bd;
        logic [1:0]   bb;
        logic [127:0] nd;
        logic [1:0]   nb;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic [1:0] w, input logic [4:0] a0,
                       input logic [63:0] d0, input logic [4:0] a1, input logic [63:0] d1,
                       input logic re, input logic [4:0] ra, input logic [4:0] r0,
                       input logic [4:0] r1, input logic [63:0] bd0, input logic [63:0] bd1,
                       input logic [1:0] bb, input logic [63:0] nd0, input logic [63:0] nd1,
                       input logic [1:0] nb);
        vecs.push_back('{name, w, a0, d0, a1, d1, re, ra, r0, r1, bd0, bd1, bb, nd0, nd1, nb});
    endtask

    task automatic check_pop();
        exp_t e;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL sb_empty: got no expectation, expected one");
        end else begin
            e = sb_q.pop_front();
            chk({e.name, "_byp_data"}, rd_data, e.bd);
            chk({e.name, "_byp_busy"}, 128'(rd_busy), 128'(e.bb));
            chk({e.name, "_nb_data"}, rd_data_nb, e.nd);
            chk({e.name, "_nb_busy"}, 128'(rd_busy_nb), 128'(e.nb));
        end
    endtask

    task automatic idle();
        we = '0; wa = '0; wd = '0; rsv_en = 1'b0; rsv_addr = '0;
    endtask

    // Entered just after an edge with rst high; releases rst and counts cycles to ready.
    task automatic run_sweep(input string tag);
        int cycles;
        bit done;
        cycles = 0;
        done   = 1'b0;
        rst = 1'b0;
        we = 2'b11; wa = {5'd9, 5'd5}; wd = {64'hBAD9, 64'hBAD5};
        rsv_en = 1'b1; rsv_addr = 5'd5;
        rd_addr = {5'd9, 5'd5};
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (k == 3 || k == 20) begin
                sb_q.push_back('{{tag, "_sweep_mask"}, 128'd0, 2'b00, 128'd0, 2'b00});
                check_pop();
            end
            @(posedge clk);
            #1;
            cycles++;
            if (ready) done = 1'b1;
        end
        idle();
        chk({tag, "_ready_cycles"}, 128'(cycles), 128'd31);
        chk({tag, "_ready_nb"}, 128'(ready_nb), 128'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle();
        rd_addr = {5'd6, 5'd5};
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 128'({ready, ready_nb}), 128'd0);
        chk("rst_outputs", {rd_data[63:0], rd_data_nb[63:0]}, 128'd0);
        chk("rst_busy", 128'({rd_busy, rd_busy_nb}), 128'd0);
        run_sweep("init");

        add("swp_x5",    2'b00, 5'd0, 64'h0,        5'd0, 64'h0,  1'b0, 5'd0, 5'd5, 5'd31,
            64'h0, 64'h0, 2'b00, 64'h0, 64'h0, 2'b00);
        add("wr_x5",     2'b01, 5'd5, 64'hDEADBEEF, 5'd0, 64'h0,  1'b0, 5'd0, 5'd5, 5'd0,
            64'hDEADBEEF, 64'h0, 2'b00, 64'h0, 64'h0, 2'b00);
        add("rd_x5",     2'b00, 5'd0, 64'h0,        5'd0, 64'h0,  1'b0, 5'd0, 5'd5, 5'd5,
            64'hDEADBEEF, 64'hDEADBEEF, 2'b00, 64'hDEADBEEF, 64'hDEADBEEF, 2'b00);
        add("wr_x0",     2'b01, 5'd0, 64'h1234,     5'd0, 64'h0,  1'b0, 5'd0, 5'd0, 5'd5,
            64'h0, 64'hDEADBEEF, 2'b00, 64'h0, 64'hDEADBEEF, 2'b00);
        add("rd_x0",     2'b00, 5'd0, 64'h0,        5'd0, 64'h0,  1'b0, 5'd0, 5'd0, 5'd5,
            64'h0, 64'hDEADBEEF, 2'b00, 64'h0, 64'hDEADBEEF, 2'b00);
        add("byp_x7",    2'b01, 5'd7, 64'h55,       5'd0, 64'h0,  1'b0, 5'd0, 5'd5, 5'd7,
            64'hDEADBEEF, 64'h55, 2'b00, 64'hDEADBEEF, 64'h0, 2'b00);
        add("rd_x7",     2'b00, 5'd0, 64'h0,        5'd0, 64'h0,  1'b0, 5'd0, 5'd5, 5'd7,
            64'hDEADBEEF, 64'h55, 2'b00, 64'hDEADBEEF, 64'h55, 2'b00);
        add("conf_x9",   2'b11, 5'd9, 64'h11,       5'd9, 64'h22, 1'b0, 5'd0, 5'd7, 5'd9,
            64'h55, 64'h22, 2'b00, 64'h55, 64'h0, 2'b00);
        add("rd_x9",     2'b00, 5'd0, 64'h0,        5'd0, 64'h0,  1'b0, 5'd0, 5'd9, 5'd7,
            64'h22, 64'h55, 2'b00, 64'h22, 64'h55, 2'b00);
        add("rsv_x3",    2'b00, 5'd0, 64'h0,        5'd0, 64'h0,  1'b1, 5'd3, 5'd3, 5'd0,
            64'h0, 64'h0, 2'b00, 64'h0, 64'h0, 2'b00);
        add("busy_x3",   2'b00, 5'd0, 64'h0,        5'd0, 64'h0,  1'b0, 5'd0, 5'd3, 5'd0,
            64'h0, 64'h0, 2'b01, 64'h0, 64'h0, 2'b01);
        add("wr_rsv_x3", 2'b01, 5'd3, 64'hAA,       5'd0, 64'h0,  1'b1, 5'd3, 5'd3, 5'd0,
            64'hAA, 64'h0, 2'b01, 64'h0, 64'h0, 2'b01);
        add("hold_x3",   2'b00, 5'd0, 64'h0,        5'd0, 64'h0,  1'b0, 5'd0, 5'd3, 5'd0,
            64'hAA, 64'h0, 2'b01, 64'hAA, 64'h0, 2'b01);
        add("clr_x3",    2'b01, 5'd3, 64'hBB,       5'd0, 64'h0,  1'b0, 5'd0, 5'd3, 5'd3,
            64'hBB, 64'hBB, 2'b00, 64'hAA, 64'hAA, 2'b11);
        add("idle_x3",   2'b00, 5'd0, 64'h0,        5'd0, 64'h0,  1'b0, 5'd0, 5'd3, 5'd0,
            64'hBB, 64'h0, 2'b00, 64'hBB, 64'h0, 2'b00);
        add("rsv_x0",    2'b00, 5'd0, 64'h0,        5'd0, 64'h0,  1'b1, 5'd0, 5'd0, 5'd0,
            64'h0, 64'h0, 2'b00, 64'h0, 64'h0, 2'b00);
        add("nobusy_x0", 2'b00, 5'd0, 64'h0,        5'd0, 64'h0,  1'b0, 5'd0, 5'd0, 5'd0,
            64'h0, 64'h0, 2'b00, 64'h0, 64'h0, 2'b00);
        add("wr_x4",     2'b01, 5'd4, 64'h99,       5'd0, 64'h0,  1'b0, 5'd0, 5'd4, 5'd6,
            64'h99, 64'h0, 2'b00, 64'h0, 64'h0, 2'b00);
        add("rsv_x4",    2'b00, 5'd0, 64'h0,        5'd0, 64'h0,  1'b1, 5'd4, 5'd4, 5'd6,
            64'h99, 64'h0, 2'b00, 64'h99, 64'h0, 2'b00);
        add("rsv_x6",    2'b00, 5'd0, 64'h0,        5'd0, 64'h0,  1'b1, 5'd6, 5'd4, 5'd6,
            64'h99, 64'h0, 2'b01, 64'h99, 64'h0, 2'b01);
        add("busy_46",   2'b00, 5'd0, 64'h0,        5'd0, 64'h0,  1'b0, 5'd0, 5'd4, 5'd6,
            64'h99, 64'h0, 2'b11, 64'h99, 64'h0, 2'b11);

        foreach (vecs[n]) begin
            @(posedge clk);
            #1;
            we       = vecs[n].we;
            wa       = {vecs[n].wa1, vecs[n].wa0};
            wd       = {vecs[n].wd1, vecs[n].wd0};
            rsv_en   = vecs[n].rsv_en;
            rsv_addr = vecs[n].rsv_addr;
            rd_addr  = {vecs[n].ra1, vecs[n].ra0};
            sb_q.push_back('{vecs[n].name, {vecs[n].bd1, vecs[n].bd0}, vecs[n].bb,
                             {vecs[n].nd1, vecs[n].nd0}, vecs[n].nb});
            @(negedge clk);
            check_pop();
        end

        // Reset in the middle of run with x4/x6 busy and x4 holding data.
        @(posedge clk);
        #1;
        idle();
        rst = 1'b1;
        rd_addr = {5'd6, 5'd4};
        @(posedge clk);
        #1;
        chk("midrst_ready", 128'({ready, ready_nb}), 128'd0);
        chk("midrst_busy", 128'({rd_busy, rd_busy_nb}), 128'd0);
        run_sweep("midrst");
        rd_addr = {5'd6, 5'd4};
        sb_q.push_back('{"post_sweep_x4", 128'd0, 2'b00, 128'd0, 2'b00});
        @(negedge clk);
        check_pop();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
